// File: rtl/cdc_pkg.sv
// Shared types and default constants for the 4-phase handshake transmitter.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  localparam int CDC_DW     = 8;
  localparam int CDC_SYNC_W = 2;

endpackage

// File: rtl/sync_h.sv
// Single-bit multi-stage synchronizer with asynchronous active-high reset.
module sync_h #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [stages-1:0] chain;

  // Shift the asynchronous input through the flop chain; the last stage is safe to use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {stages{1'b0}};
    end else begin
      chain <= {chain[stages-2:0], d};
    end
  end

  assign q = chain[stages-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// Source side of a 4-phase req/ack handshake carrying a dw-bit payload to another clock domain.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int dw     = CDC_DW,
  parameter int sync_w = CDC_SYNC_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [dw-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          tx_done,
  output logic          req,
  output logic [dw-1:0] data_o,
  input  logic          ack_i
);

  state_t        state;
  state_t        state_nxt;
  logic          ack_s;
  logic          req_nxt;
  logic          done_nxt;
  logic [dw-1:0] data_nxt;

  sync_h #(
    .stages(sync_w)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (ack_i),
    .q  (ack_s)
  );

  // A stale ack still visible in IDLE blocks new transfers until the far side settles.
  assign tx_ready = (state == IDLE) & ~ack_s;

  // Next-state and next-output decode for the handshake sequence.
  always_comb begin
    state_nxt = state;
    req_nxt   = req;
    data_nxt  = data_o;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid & tx_ready) begin
          state_nxt = REQ_HI;
          req_nxt   = 1'b1;
          data_nxt  = tx_data;
        end else begin
          req_nxt   = 1'b0;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          state_nxt = REQ_LO;
          req_nxt   = 1'b0;
        end else begin
          req_nxt   = 1'b1;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          req_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  // State, request, payload and completion registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req     <= 1'b0;
      data_o  <= {dw{1'b0}};
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      req     <= req_nxt;
      data_o  <= data_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx with a transaction-level reference model and per-cycle comparison.
module tb_cdc_hs_tx;

  localparam int DW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tx_data = 8'h00;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic          tx_done;
  logic          req;
  logic [DW-1:0] data_o;
  logic          ack_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  cdc_hs_tx #(.dw(DW), .sync_w(SW)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .req(req), .data_o(data_o),
    .ack_i(ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is in flight from accept until the far side's ack
  // has been seen to rise and then fall; ack is only visible SW edges after sampling.
  bit            m_busy = 1'b0;
  bit            m_req  = 1'b0;
  bit            m_done = 1'b0;
  logic [DW-1:0] m_data = 8'h00;
  bit            m_seen [SW] = '{default: 1'b0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_req = 1'b0; m_done = 1'b0; m_data = 8'h00;
      for (int i = 0; i < SW; i++) m_seen[i] = 1'b0;
    end else begin
      bit vis;
      vis = m_seen[SW-1];
      m_done = 1'b0;
      if (!m_busy) begin
        if (tx_valid && !vis) begin
          m_busy = 1'b1; m_req = 1'b1; m_data = tx_data;
        end
      end else if (m_req && vis) begin
        m_req = 1'b0;
      end else if (!m_req && !vis) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
      for (int i = SW-1; i > 0; i--) m_seen[i] = m_seen[i-1];
      m_seen[0] = ack_i;
    end
  end

  always @(negedge clk) begin
    chk("req", req, m_req);
    chk("data_o", data_o, m_data);
    chk("tx_done", tx_done, m_done);
    chk("tx_ready", tx_ready, !m_busy && !m_seen[SW-1]);
    if (tx_done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Far-side responder: raise ack, wait for req to drop, release ack, wait for tx_done.
  task automatic finish_hs(input string tag);
    bit seen;
    ack_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (!req) seen = 1'b1;
    end
    chk({tag, "_req_fall"}, seen, 1'b1);
    ack_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (tx_done) seen = 1'b1;
    end
    chk({tag, "_done"}, seen, 1'b1);
  endtask

  initial begin
    int base;
    tick();
    chk("rst_req", req, 1'b0);
    chk("rst_data", data_o, 8'h00);
    chk("rst_done", tx_done, 1'b0);
    tick();
    rst = 1'b0;
    chk("rel_ready", tx_ready, 1'b1);
    tick();

    // Single transfer with edge-exact timing.
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("t1_req", req, 1'b1);
    chk("t1_data", data_o, 8'hA5);
    ack_i = 1'b1;
    tick(); tick();
    chk("t1_req_e2", req, 1'b1);
    tick();
    chk("t1_req_e3", req, 1'b0);
    ack_i = 1'b0;
    tick(); tick();
    chk("t1_done_e2", tx_done, 1'b0);
    tick();
    chk("t1_done_e3", tx_done, 1'b1);
    chk("t1_ready", tx_ready, 1'b1);
    tick();
    chk("t1_done_off", tx_done, 1'b0);

    // tx_valid held high across two payloads.
    base = done_cnt;
    tx_data = 8'h01; tx_valid = 1'b1;
    tick();
    chk("t2_data1", data_o, 8'h01);
    tx_data = 8'h02;
    finish_hs("t2a");
    chk("t2_data_at_done", data_o, 8'h01);
    tick();
    chk("t2_req2", req, 1'b1);
    chk("t2_data2", data_o, 8'h02);
    tx_valid = 1'b0;
    finish_hs("t2b");
    tick(); tick();
    chk("t2_count", done_cnt - base, 2);

    // Payload changes while busy are ignored.
    tx_data = 8'h01; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_data = 8'hFF;
    tick();
    chk("t3_hi_data", data_o, 8'h01);
    ack_i = 1'b1;
    tick(); tick(); tick();
    chk("t3_lo_req", req, 1'b0);
    chk("t3_lo_data", data_o, 8'h01);
    ack_i = 1'b0;
    tick(); tick(); tick();
    chk("t3_done", tx_done, 1'b1);
    chk("t3_idle_data", data_o, 8'h01);
    tick();

    // Stuck ack in IDLE blocks the transfer until it drops.
    ack_i = 1'b1;
    tick(); tick(); tick();
    tx_data = 8'h3C; tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_ready_low", tx_ready, 1'b0);
      chk("t4_req_low", req, 1'b0);
    end
    ack_i = 1'b0;
    tick(); tick();
    chk("t4_req_e2", req, 1'b0);
    tick();
    chk("t4_req_e3", req, 1'b1);
    chk("t4_data", data_o, 8'h3C);
    tx_valid = 1'b0;
    finish_hs("t4");
    tick();

    // Reset in the middle of REQ_HI.
    base = done_cnt;
    tx_data = 8'h5A; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    chk("t5_pre_req", req, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_req", req, 1'b0);
    chk("t5_data", data_o, 8'h00);
    chk("t5_done", tx_done, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_ready", tx_ready, 1'b1);
    tick(); tick(); tick();
    chk("t5_no_done", done_cnt - base, 0);

    // Sub-cycle ack glitch must not move the FSM.
    tx_data = 8'h77; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    ack_i = 1'b1;
    #3;
    ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_req_hold", req, 1'b1);
    end
    chk("t6_data", data_o, 8'h77);
    finish_hs("t6");
    tick(); tick();

    chk("total_done", done_cnt, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
